uart_tx_buffered: RTL and testbench

Buffered UART transmitter: the transmit-side counterpart to `uart_rx`. It accepts bytes from on-chip logic through a valid/ready handshake into an internal FIFO, then serializes them on `tx_pin` as 8N1 frames, LSB first. Back-to-back frames are sent with no idle gap. It runs in the `clk60` domain next to `uart_rx` and uses the same `CLKDIV` convention, so both ends agree on the bit rate.

---
 rtl/uart_tx_buffered.sv | 152 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a serializer.
// Frames go out LSB first, back to back with no idle gap.
module uart_tx_buffered #(
    parameter int CLKDIV = 15,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [AW:0]   used_slots,
    output logic          tx_pin,
    output logic          tx_busy
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = $clog2(CLKDIV);

    localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   SLOT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          push;
    logic          pop;
    logic          expire;
    logic [7:0]    head;

    // Ready comes only from the registered count, never from din_valid.
    assign din_ready  = (count != FULL);
    assign used_slots = count;
    assign push       = din_valid & din_ready;
    assign expire     = (baud == '0);
    assign head       = mem[rd_ptr];

    // Pop when idle with data, or when a stop bit ends and more is queued.
    assign pop = (count != '0) &&
                 ((state == IDLE) || ((state == STOP) && expire));

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + SLOT_ONE;
                2'b01:   count <= count - SLOT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Serializer FSM; tx_pin is a flop so the pad never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_pin  <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_pin  <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop) begin
                        shift   <= head;
                        baud    <= RELOAD;
                        tx_pin  <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (!expire) begin
                        baud <= baud - CNT_ONE;
                    end else begin
                        baud    <= RELOAD;
                        tx_pin  <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        baud <= baud - CNT_ONE;
                    end else begin
                        baud    <= RELOAD;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx_pin <= 1'b1;
                            state  <= STOP;
                        end else begin
                            tx_pin <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (!expire) begin
                        baud <= baud - CNT_ONE;
                    end else if (pop) begin
                        shift  <= head;
                        baud   <= RELOAD;
                        tx_pin <= 1'b0;
                        state  <= START;
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed steps, scoreboard of accepted bytes,
// and a cycle-exact serial monitor that decodes every frame.
module tb_uart_tx_buffered;

    localparam int CLKDIV = 15;
    localparam int AW     = 2;
    localparam int FRAME  = 10 * CLKDIV;

    logic          clk;
    logic          rst;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic [AW:0]   used_slots;
    logic          tx_pin;
    logic          tx_busy;

    int            tests;
    int            fails;
    logic [7:0]    sb [$];
    int            peak;
    int            n;
    logic          saw_full;
    int            max_used;

    uart_tx_buffered #(
        .CLKDIV(CLKDIV),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .used_slots(used_slots),
        .tx_pin    (tx_pin),
        .tx_busy   (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte (caller sits on a negedge); returns on the negedge
    // after the accepting edge. Tracks full-FIFO back-pressure.
    task automatic send(input logic [7:0] b);
        int  k;
        logic was_low;
        din       = b;
        din_valid = 1'b1;
        was_low   = 1'b0;
        for (k = 0; k < 5000; k++) begin
            if (int'(used_slots) > max_used) max_used = int'(used_slots);
            if (din_ready) break;
            if (used_slots == 4) saw_full = 1'b1;
            was_low = 1'b1;
            @(negedge clk);
        end
        if (k == 5000) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            if (was_low) chk("ready_after_pop", used_slots, 32'd3);
            sb.push_back(b);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    // Count negedges with tx_busy high, starting at the current one.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (tx_busy === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt == 5000) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Serial monitor: every cycle of every bit must hold the right level.
    initial begin : monitor
        logic [7:0] data;
        logic       ok;
        logic       abort;
        logic       v;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx_pin !== 1'b0) continue;
            data  = '0;
            ok    = 1'b1;
            abort = 1'b0;
            for (int b = 0; b < 10 && !abort; b++) begin
                for (int c = 0; c < CLKDIV; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        abort = 1'b1;
                        break;
                    end
                    v = tx_pin;
                    if (tx_busy !== 1'b1) ok = 1'b0;
                    if (b == 0 && v !== 1'b0) ok = 1'b0;
                    if (b == 9 && v !== 1'b1) ok = 1'b0;
                    if (b >= 1 && b <= 8) begin
                        if (c == 0) data[b-1] = v;
                        else if (v !== data[b-1]) ok = 1'b0;
                    end
                end
            end
            if (!abort) begin
                chk("rx_frame_shape", {31'd0, ok}, 32'd1);
                if (sb.size() == 0) begin
                    chk("rx_unexpected", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    chk("rx_byte", {24'd0, data}, {24'd0, exp});
                end
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        max_used  = 0;
        saw_full  = 1'b0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_pin", tx_pin, 32'd1);
        chk("rst_busy", tx_busy, 32'd0);
        chk("rst_used", used_slots, 32'd0);
        chk("rst_ready", din_ready, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: latency and exact busy length
        send(8'h55);
        chk("single_used_n", used_slots, 32'd1);
        chk("single_pin_n", tx_pin, 32'd1);
        @(negedge clk);
        chk("single_used_n1", used_slots, 32'd0);
        chk("single_pin_n1", tx_pin, 32'd0);
        chk("single_busy_n1", tx_busy, 32'd1);
        wait_idle(n);
        chk("single_busy_len", n, FRAME);
        repeat (3) @(negedge clk);

        // Burst of three: peak occupancy 2, 450 cycles with no gap
        send(8'hA5);
        peak = int'(used_slots);
        send(8'h00);
        if (int'(used_slots) > peak) peak = int'(used_slots);
        send(8'hFF);
        if (int'(used_slots) > peak) peak = int'(used_slots);
        chk("burst_peak", peak, 32'd2);
        wait_idle(n);
        chk("burst_busy_len", n + 1, 3 * FRAME);
        chk("burst_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        // Full FIFO with din_valid held high
        max_used = 0;
        for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
        chk("full_seen", saw_full, 32'd1);
        chk("full_max_used", max_used, 32'd4);
        wait_idle(n);
        chk("full_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        // Push on the edge where STOP expires with one byte queued
        send(8'h3C);
        send(8'hC3);
        chk("simul_used_before", used_slots, 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        chk("simul_stop_pin", tx_pin, 32'd1);
        chk("simul_used_pre", used_slots, 32'd1);
        send(8'h96);
        chk("simul_used_after", used_slots, 32'd1);
        chk("simul_start_pin", tx_pin, 32'd0);
        chk("simul_busy", tx_busy, 32'd1);
        wait_idle(n);
        chk("simul_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-frame, no clock edge in between
        send(8'hE7);
        send(8'h18);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx_pin", tx_pin, 32'd1);
        chk("arst_busy", tx_busy, 32'd0);
        chk("arst_used", used_slots, 32'd0);
        chk("arst_ready", din_ready, 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_idle_pin", tx_pin, 32'd1);

        // Pointer wrap-around: 3 x depth random bytes
        for (int i = 0; i < 3 * (2 ** AW); i++) begin
            send(8'($urandom_range(0, 255)));
        end
        wait_idle(n);
        chk("wrap_drained", sb.size(), 32'd0);
        chk("final_pin", tx_pin, 32'd1);
        chk("final_used", used_slots, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
